// File: rtl/id_flush_ctrl_if.sv
// Hazard/flush control bundle between the SCPU pipeline and id_flush_ctrl.
// The pipeline side (master) drives EX/ID/MEM status; the controller (slave)
// returns stall, flush and NOP-select controls plus debug visibility.
interface id_flush_ctrl_if;
    logic       ex_redirect;
    logic       ex_is_mret;
    logic       ex_trap;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       dmem_ready;

    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_flush;
    logic       exmem_stall;
    logic       id_inst_sel_nop;
    logic [1:0] squash_cnt;
    logic [1:0] ctrl_state;

    modport master (
        output ex_redirect, ex_is_mret, ex_trap, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, dmem_ready,
        input  pc_stall, ifid_stall, idex_flush, exmem_stall,
               id_inst_sel_nop, squash_cnt, ctrl_state
    );

    modport slave (
        input  ex_redirect, ex_is_mret, ex_trap, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, dmem_ready,
        output pc_stall, ifid_stall, idex_flush, exmem_stall,
               id_inst_sel_nop, squash_cnt, ctrl_state
    );
endinterface

// File: rtl/id_flush_ctrl.sv
// Pipeline hazard and flush sequencer for the 5-stage SCPU.
// Chooses per cycle whether the ID instruction passes or becomes a NOP, and
// raises PC/IF-ID/EX-MEM stalls and the ID/EX load bubble. Control outputs
// are combinational from the registered state/counter and the current inputs.
module id_flush_ctrl #(
    parameter int unsigned REDIRECT_SLOTS = 2,
    parameter int unsigned TRAP_SLOTS     = 2,
    parameter logic [31:0] NOP_INST       = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst,
    id_flush_ctrl_if.slave bus
);

    // Reject slot counts the 2-bit counter cannot sequence, and a NOP
    // encoding that is not an OP-IMM instruction.
    if (REDIRECT_SLOTS < 1 || REDIRECT_SLOTS > 3 ||
        TRAP_SLOTS < 1 || TRAP_SLOTS > 3 ||
        NOP_INST[6:0] != 7'b0010011) begin : g_bad_params
        $error("id_flush_ctrl: illegal parameter values");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SQUASH   = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Remaining squash slots after the event cycle itself.
    localparam logic [1:0] REDIRECT_LOAD = 2'(REDIRECT_SLOTS - 1);
    localparam logic [1:0] TRAP_LOAD     = 2'(TRAP_SLOTS - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic       load_use;
    logic       any_event;
    logic [1:0] load_val;

    // Hazard detection and event classification.
    always_comb begin
        load_use  = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
        any_event = bus.ex_trap || bus.ex_is_mret || bus.ex_redirect;
        load_val  = (bus.ex_trap || bus.ex_is_mret) ? TRAP_LOAD : REDIRECT_LOAD;
    end

    // Next-state/counter and combinational control outputs.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        bus.pc_stall        = 1'b0;
        bus.ifid_stall      = 1'b0;
        bus.idex_flush      = 1'b0;
        bus.exmem_stall     = 1'b0;
        bus.id_inst_sel_nop = 1'b0;
        bus.squash_cnt      = 2'd0;
        bus.ctrl_state      = 2'd0;

        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            bus.ctrl_state = state_q;
            case (state_q)
                // The first ready cycle of MEM_WAIT is evaluated exactly as RUN.
                RUN, MEM_WAIT: begin
                    if (!bus.dmem_ready) begin
                        bus.pc_stall    = 1'b1;
                        bus.ifid_stall  = 1'b1;
                        bus.exmem_stall = 1'b1;
                        state_d         = MEM_WAIT;
                    end else if (any_event) begin
                        bus.id_inst_sel_nop = 1'b1;
                        bus.squash_cnt      = load_val;
                        cnt_d               = load_val;
                        state_d             = (load_val != 2'd0) ? SQUASH : RUN;
                    end else if (load_use) begin
                        bus.pc_stall   = 1'b1;
                        bus.ifid_stall = 1'b1;
                        bus.idex_flush = 1'b1;
                        state_d        = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                // Memory stalls inside a window keep SQUASH with a frozen counter.
                SQUASH: begin
                    bus.id_inst_sel_nop = 1'b1;
                    bus.squash_cnt      = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                    if (!bus.dmem_ready) begin
                        bus.pc_stall    = 1'b1;
                        bus.ifid_stall  = 1'b1;
                        bus.exmem_stall = 1'b1;
                    end else if (any_event) begin
                        cnt_d   = load_val;
                        state_d = (load_val != 2'd0) ? SQUASH : RUN;
                    end else begin
                        cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                        state_d = (cnt_q <= 2'd1) ? RUN : SQUASH;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and squash counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_flush_ctrl.sv
// Scoreboard bench for id_flush_ctrl. Two instances: A uses 2/2 slots, B uses
// REDIRECT_SLOTS=1 / TRAP_SLOTS=3. Both see the same inputs; each vector
// targets one instance. Expected vector layout:
// {pc_stall, ifid_stall, idex_flush, exmem_stall, nop, squash_cnt[1:0], ctrl_state[1:0]}
module tb_id_flush_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_flush_ctrl_if ifa ();
    id_flush_ctrl_if ifb ();

    id_flush_ctrl #(.REDIRECT_SLOTS(2), .TRAP_SLOTS(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    id_flush_ctrl #(.REDIRECT_SLOTS(1), .TRAP_SLOTS(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    logic [9:0] exp_q[$];   // {sel, expected}
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [8:0] e(input logic pc, input logic ifid, input logic idex,
                                     input logic exm, input logic nop,
                                     input logic [1:0] cnt, input logic [1:0] st);
        return {pc, ifid, idex, exm, nop, cnt, st};
    endfunction

    task automatic drive(input logic r, input logic trap, input logic mret, input logic red,
                         input logic dmem, input logic load, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        rst             = r;
        ifa.ex_trap     = trap;  ifb.ex_trap     = trap;
        ifa.ex_is_mret  = mret;  ifb.ex_is_mret  = mret;
        ifa.ex_redirect = red;   ifb.ex_redirect = red;
        ifa.dmem_ready  = dmem;  ifb.dmem_ready  = dmem;
        ifa.ex_is_load  = load;  ifb.ex_is_load  = load;
        ifa.ex_rd       = rd;    ifb.ex_rd       = rd;
        ifa.id_rs1      = rs1;   ifb.id_rs1      = rs1;
        ifa.id_rs2      = rs2;   ifb.id_rs2      = rs2;
        ifa.id_use_rs1  = u1;    ifb.id_use_rs1  = u1;
        ifa.id_use_rs2  = u2;    ifb.id_use_rs2  = u2;
    endtask

    // One clock cycle: apply inputs just after the edge and queue the expectation.
    task automatic cyc(input string nm, input logic sel, input logic r,
                       input logic trap, input logic mret, input logic red, input logic dmem,
                       input logic load, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [8:0] exp);
        @(posedge clk);
        #1;
        drive(r, trap, mret, red, dmem, load, rd, rs1, rs2, u1, u2);
        exp_q.push_back({sel, exp});
        name_q.push_back(nm);
    endtask

    task automatic ev(input string nm, input logic sel, input logic r, input logic trap,
                      input logic mret, input logic red, input logic dmem,
                      input logic [8:0] exp);
        cyc(nm, sel, r, trap, mret, red, dmem, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp);
    endtask

    task automatic idle(input string nm, input logic sel, input logic [8:0] exp);
        ev(nm, sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    task automatic lu(input string nm, input logic sel, input logic red, input logic dmem,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [8:0] exp);
        cyc(nm, sel, 1'b0, 1'b0, 1'b0, red, dmem, 1'b1, rd, rs1, rs2, u1, u2, exp);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        logic [9:0] ent;
        logic [8:0] act;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (ent[9])
                    act = {ifb.pc_stall, ifb.ifid_stall, ifb.idex_flush, ifb.exmem_stall,
                           ifb.id_inst_sel_nop, ifb.squash_cnt, ifb.ctrl_state};
                else
                    act = {ifa.pc_stall, ifa.ifid_stall, ifa.idex_flush, ifa.exmem_stall,
                           ifa.id_inst_sel_nop, ifa.squash_cnt, ifa.ctrl_state};
                checks++;
                if (act !== ent[8:0]) begin
                    errors++;
                    $display("FAIL %s (dut %s): got %b expected %b",
                             nm, ent[9] ? "B" : "A", act, ent[8:0]);
                end
            end
        end
    end

    localparam logic A = 1'b0;
    localparam logic B = 1'b1;

    initial begin
        logic [8:0] z, stl, lus;
        z   = e(0, 0, 0, 0, 0, 2'd0, 2'd0);
        stl = e(1, 1, 0, 1, 0, 2'd0, 2'd0);
        lus = e(1, 1, 1, 0, 0, 2'd0, 2'd0);
        drive(1'b1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // ---- instance A: REDIRECT_SLOTS=2, TRAP_SLOTS=2 ----
        ev("reset0", A, 1, 0, 0, 0, 1, z);
        ev("reset1", A, 1, 0, 0, 0, 1, z);
        idle("run_idle", A, z);
        ev("br_c0", A, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        idle("br_c1", A, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("br_c2", A, z);
        lu("lu_rs2", A, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, lus);
        idle("lu_after", A, z);
        lu("lu_rd0", A, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, z);
        lu("lu_rs1", A, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, lus);
        lu("lu_rs1_unused", A, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, z);
        lu("lu_vs_redirect", A, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        idle("lu_vs_redirect_sq", A, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        ev("rst_sq_c0", A, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        ev("rst_sq_c1", A, 1, 0, 0, 0, 1, z);
        idle("rst_sq_c2", A, z);
        ev("prio_c0", A, 0, 1, 1, 0, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        idle("prio_c1", A, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("prio_c2", A, z);
        ev("prio_wait_c0", A, 0, 1, 1, 0, 0, stl);
        ev("prio_wait_c1", A, 0, 1, 1, 0, 0, e(1, 1, 0, 1, 0, 2'd0, 2'd2));
        ev("prio_wait_rel", A, 0, 1, 1, 0, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd2));
        idle("prio_wait_sq", A, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("prio_wait_end", A, z);
        ev("reload_c0", A, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        ev("reload_mret", A, 0, 0, 1, 0, 1, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("reload_c2", A, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("reload_end", A, z);
        ev("sq_lu_c0", A, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd0));
        lu("sq_lu_ignored", A, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("sq_lu_end", A, z);
        ev("mw_c0", A, 0, 0, 0, 0, 0, stl);
        idle("mw_release", A, e(0, 0, 0, 0, 0, 2'd0, 2'd2));
        idle("mw_end", A, z);
        ev("mw_lu_c0", A, 0, 0, 0, 0, 0, stl);
        lu("mw_lu_release", A, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, e(1, 1, 1, 0, 0, 2'd0, 2'd2));
        idle("mw_lu_end", A, z);
        ev("rst_mw_c0", A, 0, 0, 0, 0, 0, stl);
        ev("rst_mw_c1", A, 1, 0, 0, 0, 0, z);
        idle("rst_mw_c2", A, z);

        // ---- instance B: REDIRECT_SLOTS=1, TRAP_SLOTS=3 ----
        ev("b_reset", B, 1, 0, 0, 0, 1, z);
        idle("b_idle", B, z);
        ev("trap_c0", B, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 1, 2'd2, 2'd0));
        ev("trap_c1_wait", B, 0, 0, 0, 0, 0, e(1, 1, 0, 1, 1, 2'd1, 2'd1));
        ev("trap_c2_wait", B, 0, 0, 0, 0, 0, e(1, 1, 0, 1, 1, 2'd1, 2'd1));
        idle("trap_c3", B, e(0, 0, 0, 0, 1, 2'd1, 2'd1));
        idle("trap_c4", B, e(0, 0, 0, 0, 1, 2'd0, 2'd1));
        idle("trap_c5", B, z);
        ev("br1_c0", B, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd0, 2'd0));
        idle("br1_c1", B, z);
        ev("b_reload_c0", B, 0, 1, 0, 0, 1, e(0, 0, 0, 0, 1, 2'd2, 2'd0));
        ev("b_reload_br", B, 0, 0, 0, 1, 1, e(0, 0, 0, 0, 1, 2'd1, 2'd1));
        idle("b_reload_end", B, z);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
